intr_arbiter: RTL

INTR_ARBITER -- requirements
Module: intr_arbiter

---
 rtl/intr_arbiter_pkg.sv | 23 ++
 rtl/intr_arbiter_if.sv | 36 +++
 rtl/intr_arbiter_prio_pick.sv | 44 ++++
 rtl/intr_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/intr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// intr_pkg : SPR numbers, arbiter FSM encoding and code-width helper
// Rev 1.0
// ============================================================================
package intr_pkg;

    localparam logic [9:0] SPRN_IVPR      = 10'd63;
    localparam logic [9:0] SPRN_IVOR_BASE = 10'd400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

    // A 2-source arbiter still needs one bit of exception code.
    function automatic int code_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/intr_arbiter_if.sv
`default_nettype none
// ============================================================================
// intr_arbiter_if : source, SPR and control-unit signals of the arbiter
// Rev 1.0
// ============================================================================
interface intr_arbiter_if #(
    parameter int NSRC = 8
);
    import intr_pkg::*;

    localparam int CODE_W = code_w(NSRC);

    logic [NSRC-1:0]   src_req;
    logic [NSRC-1:0]   src_ack;
    logic              msr_ee;
    logic              spr_wr;
    logic [9:0]        spr_addr;
    logic [31:0]       spr_wd;
    logic [31:0]       spr_rd;
    logic              intr_valid;
    logic [CODE_W-1:0] excep_code;
    logic [31:0]       entry_addr;
    logic              cu_ack;

    modport master (
        output src_req, msr_ee, spr_wr, spr_addr, spr_wd, cu_ack,
        input  src_ack, spr_rd, intr_valid, excep_code, entry_addr
    );

    modport slave (
        input  src_req, msr_ee, spr_wr, spr_addr, spr_wd, cu_ack,
        output src_ack, spr_rd, intr_valid, excep_code, entry_addr
    );

endinterface
`default_nettype wire

// File: rtl/intr_arbiter_prio_pick.sv
`default_nettype none
// ============================================================================
// intr_prio_pick : cyclic priority search over an eligible vector from start
// Rev 1.0
// ============================================================================
module intr_prio_pick
    import intr_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int CODE_W = code_w(NSRC)
) (
    input  logic [NSRC-1:0]   eligible,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] win,
    output logic              valid
);

    logic [CODE_W-1:0] lo_win, hi_win;
    logic              lo_hit, hi_hit;

    // Cyclic search from start == lowest eligible index at or above start,
    // falling back to the lowest eligible index overall when none is above.
    always_comb begin
        lo_win = '0;
        hi_win = '0;
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_win = CODE_W'(i);
                lo_hit = 1'b1;
                if (CODE_W'(i) >= start) begin
                    hi_win = CODE_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
    end

    assign win   = hi_hit ? hi_win : lo_win;
    assign valid = lo_hit;

endmodule
`default_nettype wire

// File: rtl/intr_arbiter.sv
`default_nettype none
// ============================================================================
// intr_arbiter : interrupt source arbiter with IVPR/IVOR vector SPRs
// Rev 1.0
// ============================================================================
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int              NSRC     = 8,
    parameter int              RR_MODE  = 0,
    parameter logic [NSRC-1:0] MASKABLE = 8'b1111_0000
) (
    input  logic          clk,
    input  logic          rst,
    intr_arbiter_if.slave bus
);

    localparam int CODE_W = code_w(NSRC);

    state_t            state_q, state_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   req_prev_q, req_prev_d;
    logic [CODE_W-1:0] win_q, win_d;
    logic [31:0]       entry_addr_q, entry_addr_d;
    logic [15:0]       ivpr_q, ivpr_d;
    logic [11:0]       ivor_q [NSRC];
    logic [11:0]       ivor_d [NSRC];

    logic [NSRC-1:0]   eligible;
    logic [NSRC-1:0]   src_ack;
    logic [CODE_W-1:0] pick_start;
    logic [CODE_W-1:0] pick_win;
    logic              pick_valid;
    logic [31:0]       spr_rd;
    logic              spr_wd_unused;

    // ------------------------------------------------------------------
    // SPR file: IVPR keeps the upper half-word, IVOR keeps bits [15:4]
    // ------------------------------------------------------------------
    always_comb begin
        ivpr_d = ivpr_q;
        ivor_d = ivor_q;
        spr_rd = '0;
        if (bus.spr_addr == SPRN_IVPR) begin
            spr_rd = {ivpr_q, 16'h0000};
            if (bus.spr_wr) begin
                ivpr_d = bus.spr_wd[31:16];
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (bus.spr_addr == SPRN_IVOR_BASE + 10'(i)) begin
                spr_rd = {16'h0000, ivor_q[i], 4'h0};
                if (bus.spr_wr) begin
                    ivor_d[i] = bus.spr_wd[15:4];
                end
            end
        end
    end

    assign spr_wd_unused = ^bus.spr_wd[3:0];

    // ------------------------------------------------------------------
    // Pending capture: rising edge sets, acknowledge clears, set wins
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_ack[i] = (state_q == ST_ACK) && (win_q == CODE_W'(i));
        end
    end

    assign req_prev_d = bus.src_req;
    assign pending_d  = (pending_q & ~src_ack) | (bus.src_req & ~req_prev_q);
    assign eligible   = pending_q & (~MASKABLE | {NSRC{bus.msr_ee}});

    // ------------------------------------------------------------------
    // Search start: rotating pointer in round-robin mode, else index 0
    // ------------------------------------------------------------------
    generate
        if (RR_MODE != 0) begin : g_rr
            logic [CODE_W-1:0] ptr_q, ptr_d;

            always_comb begin
                ptr_d = ptr_q;
                if (state_q == ST_ACK) begin
                    ptr_d = (win_q == CODE_W'(NSRC - 1)) ? '0 : win_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end

            assign pick_start = ptr_q;
        end else begin : g_fixed
            assign pick_start = '0;
        end
    endgenerate

    intr_prio_pick #(
        .NSRC   (NSRC),
        .CODE_W (CODE_W)
    ) u_pick (
        .eligible (eligible),
        .start    (pick_start),
        .win      (pick_win),
        .valid    (pick_valid)
    );

    // ------------------------------------------------------------------
    // Grant FSM: winner and vector are frozen once PRESENT is entered
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        entry_addr_d = entry_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_d        = pick_win;
                    entry_addr_d = {ivpr_q, ivor_q[pick_win], 4'b0000};
                    state_d      = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (bus.cu_ack) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            req_prev_q   <= '0;
            win_q        <= '0;
            entry_addr_q <= '0;
            ivpr_q       <= '0;
            ivor_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            req_prev_q   <= req_prev_d;
            win_q        <= win_d;
            entry_addr_q <= entry_addr_d;
            ivpr_q       <= ivpr_d;
            ivor_q       <= ivor_d;
        end
    end

    assign bus.src_ack    = src_ack;
    assign bus.spr_rd     = spr_rd;
    assign bus.intr_valid = (state_q == ST_PRESENT);
    assign bus.excep_code = win_q;
    assign bus.entry_addr = entry_addr_q;

endmodule
`default_nettype wire
